regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (we/rd/data, captured on negedge clk) among

---
 rtl/regfile_pkg.sv | 25 ++
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/regfile_wb_arbiter.sv | 88 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and helpers for write-back arbitration
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // r0 is hardwired to zero, so a write to it is accepted but never issued
  function automatic logic writes_reg(input reg_addr_t rd);
    return rd != REG_ZERO;
  endfunction

  function automatic int unsigned count_ones(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - requester handshake and register-file write port bundle
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 2
);

  logic                         hold;
  logic [NREQ-1:0]              req_valid;
  logic [REG_ADDR_W*NREQ-1:0]   req_rd;
  logic [DATA_WIDTH*NREQ-1:0]   req_data;
  logic [NREQ-1:0]              req_ready;
  logic                         rf_we;
  logic [REG_ADDR_W-1:0]        rf_rd;
  logic [DATA_WIDTH-1:0]        rf_data;

  modport master (
    output hold, req_valid, req_rd, req_data,
    input  req_ready, rf_we, rf_rd, rf_data
  );

  modport slave (
    input  hold, req_valid, req_rd, req_data,
    output req_ready, rf_we, rf_rd, rf_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - one-hot grant picker with round-robin pointer or fixed priority
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter bit RR   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  input  logic            hold,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  start;
  logic [NREQ-1:0]   rot_req, rot_gnt;
  logic [2*NREQ-1:0] dbl_gnt;
  logic              found;

  // Rotate so the pointer position is bit 0, pick the lowest set bit, rotate back
  always_comb begin
    start   = RR ? ptr_q : '0;
    rot_req = hold ? '0 : NREQ'({valid, valid} >> start);
    rot_gnt = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot_req[k]) begin
        rot_gnt[k] = 1'b1;
        found      = 1'b1;
      end
    end
    dbl_gnt = {{NREQ{1'b0}}, rot_gnt} << start;
    grant   = dbl_gnt[NREQ-1:0] | dbl_gnt[2*NREQ-1:NREQ];
  end

  always_comb begin
    ptr_d = ptr_q;
    if (RR && advance) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          ptr_d = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port among write-back requesters
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 2,
  parameter bit RR         = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]       conflict_cnt
);

  logic [NREQ-1:0]       grant;
  logic                  advance;
  reg_addr_t             sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  we_q, we_d;
  reg_addr_t             rd_q, rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .RR   (RR)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (bus.req_valid),
    .hold    (bus.hold),
    .advance (advance),
    .grant   (grant)
  );

  // A grant is only ever raised on a valid requester, so any grant is a transfer
  assign advance = |grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = bus.req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (advance) begin
      we_d   = writes_reg(sel_rd);
      rd_d   = sel_rd;
      data_d = sel_data;
    end
    if (!bus.hold && count_ones(8'(bus.req_valid)) >= 2 && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  // Grants are masked while reset is asserted so nothing is offered mid-reset
  assign bus.req_ready = grant & {NREQ{rst}};
  assign bus.rf_we     = we_q;
  assign bus.rf_rd     = rd_q;
  assign bus.rf_data   = data_q;
  assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized model-checked bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .NREQ(N)) bus_a ();
  regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .NREQ(N)) bus_b ();
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .NREQ(N), .RR(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .conflict_cnt(cnt_a)
  );
  regfile_wb_arbiter #(.DATA_WIDTH(DW), .NREQ(N), .RR(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .conflict_cnt(cnt_b)
  );

  logic          hold;
  logic [N-1:0]  v [2];
  logic [4:0]    rd [2][N];
  logic [DW-1:0] dat [2][N];

  int            ptr [2];
  longint        cnt [2];
  longint        cmax [2];
  logic          mwe [2];
  logic [4:0]    mrd [2];
  logic [DW-1:0] mdata [2];
  logic [DW-1:0] mrf [2][NUM_REGS] = '{default: '0};
  logic [DW-1:0] brf [2][NUM_REGS] = '{default: '0};
  int            waitc [N];
  logic [N-1:0]  eg [2];
  logic [N-1:0]  ag [2];
  int            passed = 0;
  int            total = 0;

  // Register file as seen by the consumer: captures whatever the DUT drives on negedge
  always @(negedge clk) begin
    if (bus_a.rf_we) brf[0][bus_a.rf_rd] = bus_a.rf_data;
    if (bus_b.rf_we) brf[1][bus_b.rf_rd] = bus_b.rf_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply();
    bus_a.hold      = hold;
    bus_a.req_valid = v[0];
    bus_a.req_rd    = {rd[0][1], rd[0][0]};
    bus_a.req_data  = {dat[0][1], dat[0][0]};
    bus_b.hold      = hold;
    bus_b.req_valid = v[1];
    bus_b.req_rd    = {rd[1][1], rd[1][0]};
    bus_b.req_data  = {dat[1][1], dat[1][0]};
  endtask

  function automatic logic [N-1:0] model_grant(input int d);
    logic [N-1:0] g;
    g = '0;
    if (!rst || hold) return g;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (d == 0) ? (ptr[d] + k) % N : k;
      if (v[d][i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ptr[d] = 0; cnt[d] = 0; mwe[d] = 1'b0; mrd[d] = '0; mdata[d] = '0;
    end
    for (int i = 0; i < N; i++) waitc[i] = 0;
  endtask

  task automatic check_dut(input int d, input logic [N-1:0] rdy, input logic we,
                           input logic [4:0] r, input logic [DW-1:0] dd, input longint c);
    string p;
    p = (d == 0) ? "a" : "b";
    check($sformatf("%s.req_ready", p), 64'(rdy), 64'(eg[d]));
    check($sformatf("%s.rf_we", p), 64'(we), 64'(mwe[d]));
    check($sformatf("%s.rf_rd", p), 64'(r), 64'(mrd[d]));
    check($sformatf("%s.rf_data", p), 64'(dd), 64'(mdata[d]));
    check($sformatf("%s.conflict_cnt", p), c, cnt[d]);
  endtask

  task automatic sample();
    eg[0] = model_grant(0);
    eg[1] = model_grant(1);
    ag[0] = bus_a.req_ready;
    ag[1] = bus_b.req_ready;
    check_dut(0, bus_a.req_ready, bus_a.rf_we, bus_a.rf_rd, bus_a.rf_data, longint'(cnt_a));
    check_dut(1, bus_b.req_ready, bus_b.rf_we, bus_b.rf_rd, bus_b.rf_data, longint'(cnt_b));
  endtask

  task automatic advance_clk();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (mwe[d]) mrf[d][mrd[d]] = mdata[d];
    end
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        if (v[0][i] && !hold) begin
          if (ag[0][i]) begin
            check("a.starvation_bound", 64'(waitc[i] < N), 64'(1));
            waitc[i] = 0;
          end else begin
            waitc[i]++;
          end
        end
      end
      for (int d = 0; d < 2; d++) begin
        mwe[d] = 1'b0;
        if (!hold && $countones(v[d]) >= 2 && cnt[d] < cmax[d]) cnt[d]++;
        for (int i = 0; i < N; i++) begin
          if (eg[d][i]) begin
            mrd[d]   = rd[d][i];
            mdata[d] = dat[d][i];
            mwe[d]   = (rd[d][i] != 5'd0);
            ptr[d]   = (i + 1) % N;
            v[d][i]  = 1'b0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic cycle();
    apply();
    #1;
    sample();
    advance_clk();
  endtask

  task automatic gen();
    hold = ($urandom_range(0, 7) == 0);
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[d][i] && $urandom_range(0, 99) < 55) begin
          v[d][i]   = 1'b1;
          rd[d][i]  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
          dat[d][i] = $urandom;
        end
      end
    end
  endtask

  initial begin
    cmax[0] = 65535;
    cmax[1] = 3;
    hold = 1'b0;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      v[d] = '1;
      for (int i = 0; i < N; i++) begin
        rd[d][i] = 5'(i + 1);
        dat[d][i] = $urandom;
      end
    end

    apply();
    repeat (2) @(posedge clk);
    #2;
    sample();
    check("reset.ready_a", 64'(bus_a.req_ready), 64'(0));
    check("reset.rf_we_a", 64'(bus_a.rf_we), 64'(0));
    check("reset.rf_data_b", 64'(bus_b.rf_data), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    for (int c = 0; c < 5; c++) begin
      for (int d = 0; d < 2; d++) begin
        v[d] = '1;
        rd[d][0] = 5'(c + 1);
        rd[d][1] = 5'(c + 17);
        dat[d][0] = $urandom;
        dat[d][1] = $urandom;
      end
      apply();
      #1;
      sample();
      check("rr.grant_seq", 64'(ag[0]), (c % 2 == 0) ? 64'h1 : 64'h2);
      check("fixed.grant_seq", 64'(ag[1]), 64'h1);
      if (c == 4) begin
        check("a.cnt_after_4", 64'(cnt_a), 64'd4);
        check("b.cnt_saturated", 64'(cnt_b), 64'd3);
      end
      advance_clk();
    end

    for (int d = 0; d < 2; d++) begin
      v[d] = 2'b10;
      rd[d][1] = 5'd7;
      dat[d][1] = 32'hDEADBEEF;
    end
    apply();
    #1;
    sample();
    check("single.ready_a", 64'(ag[0]), 64'h2);
    check("single.ready_b", 64'(ag[1]), 64'h2);
    check("a.cnt_after_5", 64'(cnt_a), 64'd5);
    check("b.cnt_after_5", 64'(cnt_b), 64'd3);
    advance_clk();
    cycle();
    check("single.rf_we", 64'(bus_a.rf_we), 64'(0));
    check("single.r7_a", 64'(brf[0][7]), 64'hDEADBEEF);
    check("single.r7_b", 64'(brf[1][7]), 64'hDEADBEEF);

    for (int d = 0; d < 2; d++) begin
      v[d] = 2'b01;
      rd[d][0] = 5'd0;
      dat[d][0] = 32'h1234;
    end
    apply();
    #1;
    sample();
    check("r0.ready_a", 64'(ag[0]), 64'h1);
    advance_clk();
    apply();
    #1;
    sample();
    check("r0.rf_we_a", 64'(bus_a.rf_we), 64'(0));
    advance_clk();
    check("r0.reads_zero", 64'(brf[0][0]), 64'(0));

    for (int d = 0; d < 2; d++) begin
      v[d] = '1;
      rd[d][0] = 5'd9;
      rd[d][1] = 5'd10;
      dat[d][0] = $urandom;
      dat[d][1] = $urandom;
    end
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply();
      #1;
      sample();
      check("hold.ready_a", 64'(ag[0]), 64'(0));
      check("hold.cnt_a", 64'(cnt_a), 64'd5);
      advance_clk();
    end
    hold = 1'b0;
    apply();
    #1;
    sample();
    check("resume.ready_a", 64'(ag[0]), 64'h2);
    check("resume.ready_b", 64'(ag[1]), 64'h1);
    advance_clk();

    #1;
    rst = 1'b0;
    #1;
    check("areset.rf_we_a", 64'(bus_a.rf_we), 64'(0));
    check("areset.rf_we_b", 64'(bus_b.rf_we), 64'(0));
    check("areset.rf_rd_a", 64'(bus_a.rf_rd), 64'(0));
    check("areset.rf_data_a", 64'(bus_a.rf_data), 64'(0));
    check("areset.ready_a", 64'(bus_a.req_ready), 64'(0));
    check("areset.cnt_a", 64'(cnt_a), 64'(0));
    model_reset();
    v[0] = '0;
    v[1] = '0;
    apply();
    sample();
    advance_clk();
    check("areset.no_write_a", 64'(brf[0][10]), 64'(0));
    check("areset.no_write_b", 64'(brf[1][9]), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    repeat (1500) begin
      gen();
      cycle();
    end

    hold = 1'b0;
    v[0] = '0;
    v[1] = '0;
    repeat (3) cycle();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        check($sformatf("regfile[%0d].r%0d", d, r), 64'(brf[d][r]), 64'(mrf[d][r]));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
